lcd_pixel_feeder: RTL and testbench

//  Sits directly downstream of the LCD timing generator (hs/vs/de, 480x272 @ 9 MHz).

---
 rtl/lcd_pixel_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_pixel_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_feeder.sv
// lcd_pixel_feeder
// Sits behind the LCD timing generator: pulls RGB565 pixels from the frame-buffer
// read FIFO while de is high and re-times hs/vs/de by two clocks so that the
// pixels line up with their enables on the panel pins. A FIFO underflow blanks
// the remainder of the frame. Reading resumes after the next frame edge, which
// also tells the upstream side to flush the FIFO (frame_start).
// Optional build macro: PIXEL_FEEDER_BAR_EN. When it is defined, pixels that
// carry no FIFO data show eight vertical colour bars instead of FILL_COLOR.
module lcd_pixel_feeder #(
  parameter int                DATA_W     = 16,
  parameter logic              VS_POL     = 1'b0,
  parameter int                H_ACTIVE   = 480,
  parameter logic [DATA_W-1:0] FILL_COLOR = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              frame_start,
  input  logic              ufl_clr,
  output logic              ufl_sticky,
  output logic [15:0]       ufl_frames,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb
);

  // The x position is a 10-bit count, so the active width has to fit in it.
  if (H_ACTIVE < 8 || H_ACTIVE > 1023) begin : g_bad_h_active
    $error("lcd_pixel_feeder: H_ACTIVE must lie in 8..1023");
  end

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              vs_d_reg;
  logic              frame_edge;
  logic              rd_en;
  logic              underflow;
  logic              frame_start_reg;

  // stage 1: timing delayed by one clock plus the "read issued" flag
  logic              hs1_reg;
  logic              vs1_reg;
  logic              de1_reg;
  logic              rd1_reg;

  // stage 2: what the panel sees
  logic              lcd_hs_reg;
  logic              lcd_vs_reg;
  logic              lcd_de_reg;
  logic [DATA_W-1:0] lcd_rgb_reg;
  logic [DATA_W-1:0] unread_color;

  logic              ufl_sticky_reg;
  logic [15:0]       ufl_frames_reg;

  // A frame begins when vsync enters its active level. The registered copy
  // resets to 0, so releasing reset in the middle of a frame cannot fake an edge.
  assign frame_edge = (vs_in == VS_POL) && (vs_d_reg != VS_POL);

  // Previous vsync level, used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_d_reg <= 1'b0;
    else     vs_d_reg <= vs_in;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_WAIT;
    else     state_reg <= state_next;
  end

  // FSM next state: a frame edge always restarts reading. An underflow parks the FSM until that edge.
  always_comb begin
    state_next = state_reg;
    if (frame_edge) begin
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN:  if (underflow) state_next = ST_RESYNC;
        default: state_next = state_reg;
      endcase
    end
  end

  // FSM outputs: reads come only from the current state, so a cycle that carries a frame edge does not read
  always_comb begin
    rd_en     = 1'b0;
    underflow = 1'b0;
    if (state_reg == ST_RUN) begin
      rd_en     = de_in & ~fifo_empty;
      underflow = de_in & fifo_empty;
    end
  end

  assign fifo_rd_en = rd_en;

  // One-clock frame_start pulse following every frame edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_start_reg <= 1'b0;
    else     frame_start_reg <= frame_edge;
  end

  // Stage 1: delay timing by one clock while the FIFO produces the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1_reg <= 1'b0;
      vs1_reg <= 1'b0;
      de1_reg <= 1'b0;
      rd1_reg <= 1'b0;
    end else begin
      hs1_reg <= hs_in;
      vs1_reg <= vs_in;
      de1_reg <= de_in;
      rd1_reg <= rd_en;
    end
  end

`ifdef PIXEL_FEEDER_BAR_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic        bar1_reg;
  logic [9:0]  x_reg;
  logic [9:0]  x_next;
  logic [9:0]  bar_q;
  logic [2:0]  bar_idx;
  logic [15:0] bar_color;

  // Mark stage-1 pixels that will carry no FIFO data (WAIT, RESYNC or the underflow pixel itself)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bar1_reg <= 1'b0;
    else     bar1_reg <= (state_reg != ST_RUN) | underflow;
  end

  // x of the pixel entering stage 2: restarts on every de run and holds rather than wraps
  always_comb begin
    x_next = 10'd0;
    if (de1_reg) begin
      if (!lcd_de_reg)         x_next = 10'd0;
      else if (x_reg == 10'h3FF) x_next = x_reg;
      else                     x_next = x_reg + 10'd1;
    end
  end

  // x position of the pixel currently on the panel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) x_reg <= 10'd0;
    else     x_reg <= x_next;
  end

  // Colour-bar lookup: eight equal-width bars, anything past the last bar stays in bar 7
  always_comb begin
    bar_q   = x_next / 10'(BAR_W);
    bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
    case (bar_idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
    unread_color = bar1_reg ? DATA_W'(bar_color) : FILL_COLOR;
  end
`else
  assign unread_color = FILL_COLOR;
`endif

  // Stage 2: panel timing and pixel; blanking periods always carry FILL_COLOR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_hs_reg  <= 1'b0;
      lcd_vs_reg  <= 1'b0;
      lcd_de_reg  <= 1'b0;
      lcd_rgb_reg <= {DATA_W{1'b0}};
    end else begin
      lcd_hs_reg  <= hs1_reg;
      lcd_vs_reg  <= vs1_reg;
      lcd_de_reg  <= de1_reg;
      if (rd1_reg)      lcd_rgb_reg <= fifo_rdata;
      else if (de1_reg) lcd_rgb_reg <= unread_color;
      else              lcd_rgb_reg <= FILL_COLOR;
    end
  end

  // Underflow status: a new underflow beats a simultaneous clear, and the frame count saturates.
  // RESYNC blocks further underflows, so the count moves at most once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ufl_sticky_reg <= 1'b0;
      ufl_frames_reg <= 16'd0;
    end else begin
      if (underflow)    ufl_sticky_reg <= 1'b1;
      else if (ufl_clr) ufl_sticky_reg <= 1'b0;
      if (underflow && ufl_frames_reg != 16'hFFFF)
        ufl_frames_reg <= ufl_frames_reg + 16'd1;
    end
  end

  assign frame_start = frame_start_reg;
  assign ufl_sticky  = ufl_sticky_reg;
  assign ufl_frames  = ufl_frames_reg;
  assign lcd_hs      = lcd_hs_reg;
  assign lcd_vs      = lcd_vs_reg;
  assign lcd_de      = lcd_de_reg;
  assign lcd_rgb     = lcd_rgb_reg;

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// tb_lcd_pixel_feeder
// Drives a small LCD timing raster (32x4 active pixels) into lcd_pixel_feeder and
// emulates the read FIFO, which returns its read index and restarts at frame_start.
// An abstract frame-level model predicts every output on every cycle. Honours
// PIXEL_FEEDER_BAR_EN when it is defined for the build.
module tb_lcd_pixel_feeder;
  localparam int   DATA_W = 16;
  localparam logic VS_POL = 1'b0;
  localparam int   H_SYNC = 2;
  localparam int   H_BP   = 3;
  localparam int   H_ACT  = 32;
  localparam int   H_TOT  = 40;
  localparam int   V_ACT0 = 2;
  localparam int   V_ACT  = 4;
  localparam int   V_TOT  = 7;
  localparam int   FRAME_CYC = H_TOT * V_TOT;
  localparam logic [15:0] FILL = 16'h0000;
`ifdef PIXEL_FEEDER_BAR_EN
  localparam logic [15:0] LIT_X0  = 16'hFFFF;
  localparam logic [15:0] LIT_X4  = 16'hFFE0;
`else
  localparam logic [15:0] LIT_X0  = 16'h0000;
  localparam logic [15:0] LIT_X4  = 16'h0000;
`endif
  localparam logic [15:0] LIT_XL  = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs_in = 1'b1;
  logic vs_in = 1'b1;
  logic de_in = 1'b0;
  logic fifo_empty = 1'b0;
  logic fifo_rd_en;
  logic [DATA_W-1:0] fifo_rdata = '0;
  logic frame_start;
  logic ufl_clr = 1'b0;
  logic ufl_sticky;
  logic [15:0] ufl_frames;
  logic lcd_hs, lcd_vs, lcd_de;
  logic [DATA_W-1:0] lcd_rgb;

  always #5 clk = ~clk;

  lcd_pixel_feeder #(
    .DATA_W(DATA_W), .VS_POL(VS_POL), .H_ACTIVE(H_ACT), .FILL_COLOR(FILL)
  ) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
    .frame_start(frame_start), .ufl_clr(ufl_clr), .ufl_sticky(ufl_sticky),
    .ufl_frames(ufl_frames), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // raster position
  int h = 0;
  int v = 0;
  bit gen_run = 1'b0;

  // FIFO emulation
  int          fifo_idx = 0;
  logic [15:0] pend = 16'h0;

  // behavioural model: frame reading is allowed after a frame edge until an underflow
  bit          m_ok, m_prev_vs, m_prev_de, m_fs, m_sticky;
  int          m_x, m_idx;
  logic [15:0] m_frames;
  logic [18:0] m_pipe [2];   // {hs, vs, de, rgb} as the panel must see it two clocks later

  // observation
  int frame_reads = 0;
  int fs_count = 0;
  int lx = 0;
  bit prev_lcd_de = 1'b0;
  bit pin_bars = 1'b0;
  int frame_no = 0;

  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, frame %0d)", nm, act, exp, cyc, frame_no);
    end
  endtask

  function automatic logic [15:0] unread_color(input int x);
`ifdef PIXEL_FEEDER_BAR_EN
    int i;
    i = x / (H_ACT / 8);
    if (i > 7) i = 7;
    return bar_tab[i];
`else
    return FILL + 16'(x * 0);
`endif
  endfunction

  function automatic bit is_de(input int hh, input int vv);
    return (vv >= V_ACT0) && (vv < V_ACT0 + V_ACT) &&
           (hh >= H_SYNC + H_BP) && (hh < H_SYNC + H_BP + H_ACT);
  endfunction

  task automatic model_reset();
    m_ok = 0; m_prev_vs = 0; m_prev_de = 0; m_fs = 0; m_sticky = 0;
    m_x = 0; m_frames = 16'h0;
    m_pipe[0] = '0; m_pipe[1] = '0;
  endtask

  // one clock: drive at the falling edge, compare 1 ns later, then advance the model
  task automatic tick(input bit r, input bit e, input bit c);
    bit fedge, rd, uf;
    int xc;
    logic [15:0] pix;
    @(negedge clk);
    rst        = r;
    fifo_empty = e;
    ufl_clr    = c;
    fifo_rdata = pend;
    hs_in      = !(h < H_SYNC);
    vs_in      = (v == 0) ? VS_POL : !VS_POL;
    de_in      = is_de(h, v);
    #1;
    if (r) model_reset();
    chk("rd_en",       32'(fifo_rd_en),  32'(m_ok && de_in && !fifo_empty && !r));
    chk("lcd_hs",      32'(lcd_hs),      32'(m_pipe[1][18]));
    chk("lcd_vs",      32'(lcd_vs),      32'(m_pipe[1][17]));
    chk("lcd_de",      32'(lcd_de),      32'(m_pipe[1][16]));
    chk("lcd_rgb",     32'(lcd_rgb),     32'(m_pipe[1][15:0]));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("ufl_sticky",  32'(ufl_sticky),  32'(m_sticky));
    chk("ufl_frames",  32'(ufl_frames),  32'(m_frames));

    // literal bar/fill values on the first (WAIT) frame
    lx = lcd_de ? (prev_lcd_de ? lx + 1 : 0) : 0;
    prev_lcd_de = lcd_de;
    if (pin_bars && lcd_de) begin
      if (lx == 0)         chk("wait_x0",   32'(lcd_rgb), 32'(LIT_X0));
      if (lx == 4)         chk("wait_x4",   32'(lcd_rgb), 32'(LIT_X4));
      if (lx == H_ACT - 1) chk("wait_xend", 32'(lcd_rgb), 32'(LIT_XL));
    end

    // FIFO emulation: flush on frame_start, data = read index, garbage otherwise
    if (frame_start) begin
      fifo_idx = 0;
      fs_count++;
    end
    if (fifo_rd_en) begin
      pend = 16'(fifo_idx);
      fifo_idx++;
      frame_reads++;
    end else begin
      pend = 16'($urandom);
    end

    if (!r) begin
      fedge = (vs_in == VS_POL) && (m_prev_vs != VS_POL);
      rd    = m_ok && de_in && !fifo_empty;
      uf    = m_ok && de_in && fifo_empty;
      if (m_fs) m_idx = 0;
      xc = de_in ? (m_prev_de ? m_x + 1 : 0) : 0;
      if (rd) begin
        pix = 16'(m_idx);
        m_idx++;
      end else if (de_in) begin
        pix = unread_color(xc);
      end else begin
        pix = FILL;
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {hs_in, vs_in, de_in, pix};
      m_fs      = fedge;
      m_sticky  = uf ? 1'b1 : (ufl_clr ? 1'b0 : m_sticky);
      if (uf && m_frames != 16'hFFFF) m_frames = m_frames + 16'd1;
      m_ok      = fedge ? 1'b1 : (m_ok && !uf);
      m_prev_vs = vs_in;
      m_prev_de = de_in;
      m_x       = xc;
    end

    if (gen_run) begin
      h++;
      if (h == H_TOT) begin
        h = 0;
        v++;
        if (v == V_TOT) v = 0;
      end
    end
    cyc++;
  endtask

  bit cap_sticky;
  bit cap_pre_rst_rd;
  bit cap_rst_rd;

  // one full frame; pixel indices count active pixels from 0, -1 disables an event
  task automatic run_frame(input int ufl_pix, input int clr_pix, input int clr2_pix,
                           input int e_per_mil, input int c_per_mil, input int rst_cyc);
    bit d, e, c, r;
    int pix;
    frame_reads = 0;
    frame_no++;
    for (int k = 0; k < FRAME_CYC; k++) begin
      d   = is_de(h, v);
      pix = (v - V_ACT0) * H_ACT + (h - H_SYNC - H_BP);
      e   = (d && pix == ufl_pix) || (int'($urandom_range(999)) < e_per_mil);
      c   = (d && (pix == clr_pix || pix == clr2_pix)) || (int'($urandom_range(999)) < c_per_mil);
      r   = (rst_cyc >= 0) && (k >= rst_cyc) && (k < rst_cyc + 3);
      tick(r, e, c);
      if (d && ufl_pix >= 0 && pix == ufl_pix + 1) cap_sticky = ufl_sticky;
      if (k == rst_cyc - 1) cap_pre_rst_rd = fifo_rd_en;
      if (k == rst_cyc)     cap_rst_rd = fifo_rd_en;
    end
    $display("frame %0d: reads=%0d ufl_sticky=%0d ufl_frames=%0d", frame_no, frame_reads, ufl_sticky, ufl_frames);
  endtask

  initial begin
    model_reset();
    m_idx = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    chk("reset_rgb", 32'(lcd_rgb), 32'h0);
    gen_run = 1'b1;

    // frames 1-2: WAIT frame then a clean frame
    pin_bars = 1'b1;
    run_frame(-1, -1, -1, 0, 0, -1);
    pin_bars = 1'b0;
    chk("f1_reads", 32'(frame_reads), 32'd0);
    run_frame(-1, -1, -1, 0, 0, -1);
    chk("f2_reads", 32'(frame_reads), 32'(H_ACT * V_ACT));
    chk("f12_frame_starts", 32'(fs_count), 32'd1);

    // frame 3: single empty clock at pixel 50, frame 4 clean again
    run_frame(50, -1, -1, 0, 0, -1);
    chk("f3_reads", 32'(frame_reads), 32'd50);
    chk("f3_sticky", 32'(ufl_sticky), 32'd1);
    chk("f3_frames", 32'(ufl_frames), 32'd1);
    run_frame(-1, -1, -1, 0, 0, -1);
    chk("f4_reads", 32'(frame_reads), 32'(H_ACT * V_ACT));
    chk("f4_frames", 32'(ufl_frames), 32'd1);

    // frame 5: clear coincident with underflow, then a clear on its own
    run_frame(20, 20, 100, 0, 0, -1);
    chk("f5_reads", 32'(frame_reads), 32'd20);
    chk("f5_set_wins", 32'(cap_sticky), 32'd1);
    chk("f5_sticky_cleared", 32'(ufl_sticky), 32'd0);
    chk("f5_frames", 32'(ufl_frames), 32'd2);

    // randomized underflows and clears
    for (int f = 0; f < 6; f++) run_frame(-1, -1, -1, 3, 10, -1);

    // clean frame so the next one starts in RUN, then reset mid-line
    run_frame(-1, -1, -1, 0, 0, -1);
    run_frame(-1, -1, -1, 0, 0, 3 * H_TOT + 15);
    chk("rst_pre_rd", 32'(cap_pre_rst_rd), 32'd1);
    chk("rst_rd", 32'(cap_rst_rd), 32'd0);
    chk("rst_frame_reads", 32'(frame_reads), 32'(H_ACT + 10));
    chk("rst_frames", 32'(ufl_frames), 32'd0);
    run_frame(-1, -1, -1, 0, 0, -1);
    chk("post_rst_reads", 32'(frame_reads), 32'(H_ACT * V_ACT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
